// File: rtl/adder_seq_chunked_if.sv
// Handshake and operand/result bundle for the chunked sequential adder.
// The master side requests an operation; the slave side is the adder itself.
interface adder_seq_chunked_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             carryin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
    logic             carryout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, src1, src2, carryin,
        input  busy, done, res, carryout, overflow, zero
    );

    modport slave (
        input  start, sub, src1, src2, carryin,
        output busy, done, res, carryout, overflow, zero
    );
endinterface

// File: rtl/adder_seq_chunked.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LS chunk first, registered carry.
// Delivers res plus carry/overflow/zero flags with a one-cycle done pulse.
module adder_seq_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    adder_seq_chunked_if.slave  bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CNT_W-1:0] step;
    logic             carryout_reg;
    logic             overflow_reg;
    logic             zero_reg;
    logic [CHUNK:0]   sum;
    logic             accept;
    logic             last_step;
    int               offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start is honoured only outside RUN; DONE may chain straight into RUN.
    always_comb begin
        state_next = state;
        accept     = bus.start && (state == IDLE || state == DONE);
        last_step  = (state == RUN) && (step == LAST);
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        offset   = int'(step) * CHUNK;
        sum      = {1'b0, a_reg[offset +: CHUNK]} + {1'b0, b_reg[offset +: CHUNK]}
                 + {{CHUNK{1'b0}}, carry};
        res_next = res_reg;
        res_next[offset +: CHUNK] = sum[CHUNK-1:0];
    end

    // Subtraction is A + ~B + 1, so B is inverted once at latch time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            res_reg      <= '0;
            carry        <= 1'b0;
            step         <= '0;
            carryout_reg <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else if (accept) begin
            a_reg        <= bus.src1;
            b_reg        <= bus.sub ? ~bus.src2 : bus.src2;
            carry        <= bus.sub | bus.carryin;
            step         <= '0;
            res_reg      <= '0;
            carryout_reg <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else if (state == RUN) begin
            res_reg <= res_next;
            carry   <= sum[CHUNK];
            if (last_step) begin
                carryout_reg <= sum[CHUNK];
                overflow_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                             && (res_next[WIDTH-1] != a_reg[WIDTH-1]);
                zero_reg     <= (res_next == '0);
            end else begin
                step <= step + 1'b1;
            end
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.res      = res_reg;
    assign bus.carryout = carryout_reg;
    assign bus.overflow = overflow_reg;
    assign bus.zero     = zero_reg;
endmodule
